// File: rtl/sap_datapath.sv
// sap_datapath: register-level datapath of the SAP computer.
//
// Holds the PC, MAR, a 16x8 RAM, IR, ACC, B, an adder/subtractor and the
// OUT register, all sharing one combinational 8-bit bus. It executes the
// control word driven each cycle by instruction_decoder and returns the
// opcode in IR[7:5]. A host port can preload the RAM.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   inc_PC                       PC <= PC + 1 (wraps)
//   ld_MAR/ld_IR/ld_ACC/ld_Breg  load the named register from the bus
//   ld_out                       load OUT from the bus
//   ld_bus[2:0]                  bus source select
//   mem_wr                       RAM[MAR] <= bus
//   cin                          ALU mode: 0 = ACC+B, 1 = ACC-B
//   sum                          capture ALU carry/zero flags this edge
//   tx                           with ld_out, raises out_valid next cycle
//   prog_we/prog_addr/prog_data  host RAM write port (wins over mem_wr)
//   opcode                       IR[7:5]
//   out_data, out_valid          OUT register and its one-cycle strobe
//   pc                           current program counter
//   carry, zero                  registered ALU flags
module sap_datapath #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_PC,
   input  logic             ld_MAR,
   input  logic             ld_IR,
   input  logic             ld_ACC,
   input  logic             ld_Breg,
   input  logic             ld_out,
   input  logic [2:0]       ld_bus,
   input  logic             mem_wr,
   input  logic             cin,
   input  logic             sum,
   input  logic             tx,
   input  logic             prog_we,
   input  logic [AW-1:0]    prog_addr,
   input  logic [WIDTH-1:0] prog_data,
   output logic [2:0]       opcode,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic [AW-1:0]    pc,
   output logic             carry,
   output logic             zero
);

   localparam logic [2:0] BusZero = 3'd0;
   localparam logic [2:0] BusPc   = 3'd1;
   localparam logic [2:0] BusIrA  = 3'd2;
   localparam logic [2:0] BusAcc  = 3'd3;
   localparam logic [2:0] BusAlu  = 3'd4;
   localparam logic [2:0] BusRam  = 3'd5;
   localparam logic [2:0] BusB    = 3'd6;
   localparam logic [2:0] BusNone = 3'd7;

   logic [AW-1:0]    pc_q;
   logic [AW-1:0]    mar_q;
   logic [WIDTH-1:0] ir_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] out_q;
   logic             carry_q;
   logic             zero_q;
   logic             out_valid_q;

   logic [WIDTH-1:0] mem_q [2**AW];

   logic [WIDTH-1:0] bus;
   logic [WIDTH-1:0] ram_rdata;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH:0]   alu_res;

   // IR[4] is stored but has no consumer.
   logic [WIDTH-4-AW:0] unused_ir_rsvd;
   assign unused_ir_rsvd = ir_q[WIDTH-4:AW];

   assign ram_rdata = mem_q[mar_q];

   // Subtract is ACC + ~B + 1, so carry-out 1 means no borrow.
   assign alu_b   = cin ? ~b_q : b_q;
   assign alu_res = {1'b0, acc_q} + {1'b0, alu_b} + {{WIDTH{1'b0}}, cin};

   always_comb begin
      bus = '0;
      unique case (ld_bus)
         BusZero: bus = '0;
         BusPc:   bus = {{(WIDTH-AW){1'b0}}, pc_q};
         BusIrA:  bus = {{(WIDTH-AW){1'b0}}, ir_q[AW-1:0]};
         BusAcc:  bus = acc_q;
         BusAlu:  bus = alu_res[WIDTH-1:0];
         BusRam:  bus = ram_rdata;
         BusB:    bus = b_q;
         BusNone: bus = '0;
         default: bus = '0;
      endcase
   end

   // Every load samples the pre-edge bus, so self-loads and PC-as-source
   // with inc_PC naturally use the old value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= '0;
         mar_q       <= '0;
         ir_q        <= '0;
         acc_q       <= '0;
         b_q         <= '0;
         out_q       <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         if (inc_PC)  pc_q  <= pc_q + AW'(1);
         if (ld_MAR)  mar_q <= bus[AW-1:0];
         if (ld_IR)   ir_q  <= bus;
         if (ld_ACC)  acc_q <= bus;
         if (ld_Breg) b_q   <= bus;
         if (ld_out)  out_q <= bus;
         if (sum) begin
            carry_q <= alu_res[WIDTH];
            zero_q  <= (alu_res[WIDTH-1:0] == '0);
         end
         out_valid_q <= ld_out & tx;
      end
   end

   // RAM has no reset; writes are suppressed while reset is asserted so a
   // write racing reset assertion is dropped. Host write beats mem_wr.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (prog_we) begin
            mem_q[prog_addr] <= prog_data;
         end else if (mem_wr) begin
            mem_q[mar_q] <= bus;
         end
      end
   end

   assign opcode    = ir_q[WIDTH-1:WIDTH-3];
   assign out_data  = out_q;
   assign out_valid = out_valid_q;
   assign pc        = pc_q;
   assign carry     = carry_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_sap_datapath.sv
// Directed self-checking bench for sap_datapath.
module tb_sap_datapath;

   logic       clk;
   logic       rst_n;
   logic       inc_PC, ld_MAR, ld_IR, ld_ACC, ld_Breg, ld_out;
   logic [2:0] ld_bus;
   logic       mem_wr, cin, sum, tx, prog_we;
   logic [3:0] prog_addr;
   logic [7:0] prog_data;
   logic [2:0] opcode;
   logic [7:0] out_data;
   logic       out_valid;
   logic [3:0] pc;
   logic       carry, zero;

   int n_checks;
   int n_fail;

   sap_datapath #(.WIDTH(8), .AW(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc_PC    (inc_PC),
      .ld_MAR    (ld_MAR),
      .ld_IR     (ld_IR),
      .ld_ACC    (ld_ACC),
      .ld_Breg   (ld_Breg),
      .ld_out    (ld_out),
      .ld_bus    (ld_bus),
      .mem_wr    (mem_wr),
      .cin       (cin),
      .sum       (sum),
      .tx        (tx),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .opcode    (opcode),
      .out_data  (out_data),
      .out_valid (out_valid),
      .pc        (pc),
      .carry     (carry),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      inc_PC = 0; ld_MAR = 0; ld_IR = 0; ld_ACC = 0; ld_Breg = 0; ld_out = 0;
      ld_bus = 3'd0; mem_wr = 0; cin = 0; sum = 0; tx = 0;
      prog_we = 0; prog_addr = 4'd0; prog_data = 8'd0;
   endtask

   // Apply the currently driven control word for one edge, then idle.
   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic preload(input logic [3:0] a, input logic [7:0] d);
      prog_we = 1; prog_addr = a; prog_data = d;
      tick();
   endtask

   // Put v on the bus through RAM[0] (MAR=0 via the constant-zero source)
   // and load it into the selected registers.
   task automatic load_val(input logic [7:0] v, input bit to_acc, input bit to_b,
                           input bit to_mar);
      prog_we = 1; prog_addr = 4'd0; prog_data = v; ld_bus = 3'd0; ld_MAR = 1;
      tick();
      ld_bus = 3'd5; ld_ACC = to_acc; ld_Breg = to_b; ld_MAR = to_mar;
      tick();
   endtask

   task automatic read_src(input logic [2:0] src, output logic [7:0] v);
      ld_bus = src; ld_out = 1;
      tick();
      v = out_data;
   endtask

   task automatic test_reset();
      n_checks++; if (pc !== 4'd0) begin n_fail++; $display("FAIL reset_pc got %h want 0", pc); end
      n_checks++; if (opcode !== 3'd0) begin n_fail++; $display("FAIL reset_opcode got %h want 0", opcode); end
      n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out got %h want 00", out_data); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
      n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %b want 0", carry); end
      n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero got %b want 0", zero); end
   endtask

   task automatic test_fetch();
      logic [7:0] v;
      preload(4'd0, 8'h29);
      preload(4'd9, 8'h05);
      preload(4'd3, 8'h33);
      preload(4'd5, 8'h44);
      ld_bus = 3'd1; ld_MAR = 1; tick();
      ld_bus = 3'd5; ld_IR = 1; inc_PC = 1; tick();
      n_checks++; if (opcode !== 3'b001) begin n_fail++; $display("FAIL fetch_opcode got %b want 001", opcode); end
      n_checks++; if (pc !== 4'd1) begin n_fail++; $display("FAIL fetch_pc got %h want 1", pc); end
      read_src(3'd2, v);
      n_checks++; if (v !== 8'h09) begin n_fail++; $display("FAIL fetch_operand got %h want 09", v); end
      ld_bus = 3'd2; ld_MAR = 1; tick();
      read_src(3'd5, v);
      n_checks++; if (v !== 8'h05) begin n_fail++; $display("FAIL fetch_operand_data got %h want 05", v); end
   endtask

   task automatic test_alu();
      logic [7:0] v;
      load_val(8'hF0, 1, 0, 0);
      load_val(8'h20, 0, 1, 0);
      cin = 0; sum = 1; ld_bus = 3'd4; ld_ACC = 1; tick();
      n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL add_carry got %b want 1", carry); end
      n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL add_zero got %b want 0", zero); end
      read_src(3'd3, v);
      n_checks++; if (v !== 8'h10) begin n_fail++; $display("FAIL add_acc got %h want 10", v); end
      load_val(8'h10, 0, 1, 0);
      cin = 1; sum = 1; ld_bus = 3'd4; ld_ACC = 1; tick();
      n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL sub_eq_carry got %b want 1", carry); end
      n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL sub_eq_zero got %b want 1", zero); end
      read_src(3'd3, v);
      n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL sub_eq_acc got %h want 00", v); end
      load_val(8'h05, 1, 0, 0);
      load_val(8'h06, 0, 1, 0);
      cin = 1; sum = 1; ld_bus = 3'd4; ld_ACC = 1; tick();
      n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL sub_borrow_carry got %b want 0", carry); end
      n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL sub_borrow_zero got %b want 0", zero); end
      read_src(3'd3, v);
      n_checks++; if (v !== 8'hFF) begin n_fail++; $display("FAIL sub_borrow_acc got %h want FF", v); end
      // FF + 06 = 0x105 would set carry, but sum=0 must hold the flags.
      cin = 0; sum = 0; ld_bus = 3'd4; ld_ACC = 1; tick();
      n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL flag_hold_carry got %b want 0", carry); end
      read_src(3'd3, v);
      n_checks++; if (v !== 8'h05) begin n_fail++; $display("FAIL wrap_add_acc got %h want 05", v); end
   endtask

   task automatic test_pc();
      logic [7:0] v;
      rst_n = 0; #2; rst_n = 1;
      for (int i = 0; i < 15; i++) begin inc_PC = 1; tick(); end
      n_checks++; if (pc !== 4'd15) begin n_fail++; $display("FAIL pc_15 got %h want f", pc); end
      inc_PC = 1; tick();
      n_checks++; if (pc !== 4'd0) begin n_fail++; $display("FAIL pc_wrap got %h want 0", pc); end
      for (int i = 0; i < 7; i++) begin inc_PC = 1; tick(); end
      inc_PC = 1; ld_bus = 3'd1; ld_ACC = 1; tick();
      n_checks++; if (pc !== 4'd8) begin n_fail++; $display("FAIL pc_rbw_pc got %h want 8", pc); end
      read_src(3'd3, v);
      n_checks++; if (v !== 8'h07) begin n_fail++; $display("FAIL pc_rbw_acc got %h want 07", v); end
   endtask

   task automatic test_ram_collision();
      logic [7:0] v;
      load_val(8'hAA, 1, 0, 0);
      load_val(8'h03, 0, 0, 1);
      ld_bus = 3'd3; mem_wr = 1; prog_we = 1; prog_addr = 4'd5; prog_data = 8'h55; tick();
      read_src(3'd5, v);
      n_checks++; if (v !== 8'h33) begin n_fail++; $display("FAIL collide_ram3 got %h want 33", v); end
      ld_bus = 3'd3; mem_wr = 1; tick();
      read_src(3'd5, v);
      n_checks++; if (v !== 8'hAA) begin n_fail++; $display("FAIL memwr_ram3 got %h want AA", v); end
      load_val(8'h05, 0, 0, 1);
      read_src(3'd5, v);
      n_checks++; if (v !== 8'h55) begin n_fail++; $display("FAIL collide_ram5 got %h want 55", v); end
   endtask

   task automatic test_out();
      logic [7:0] v;
      load_val(8'h3C, 1, 0, 0);
      ld_bus = 3'd3; ld_out = 1; tx = 0; tick();
      n_checks++; if (out_data !== 8'h3C) begin n_fail++; $display("FAIL out_notx_data got %h want 3C", out_data); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL out_notx_valid got %b want 0", out_valid); end
      ld_bus = 3'd7; ld_out = 1; tick();
      n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL bus7_zero got %h want 00", out_data); end
      ld_bus = 3'd3; ld_out = 1; tx = 1; tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL out_tx_valid got %b want 1", out_valid); end
      n_checks++; if (out_data !== 8'h3C) begin n_fail++; $display("FAIL out_tx_data got %h want 3C", out_data); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL out_pulse_end got %b want 0", out_valid); end
      // Back-to-back strobes plus a second load sharing the same bus value.
      ld_bus = 3'd3; ld_out = 1; tx = 1; tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first got %b want 1", out_valid); end
      ld_bus = 3'd3; ld_out = 1; tx = 1; ld_Breg = 1; tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second got %b want 1", out_valid); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b want 0", out_valid); end
      read_src(3'd6, v);
      n_checks++; if (v !== 8'h3C) begin n_fail++; $display("FAIL multi_load_b got %h want 3C", v); end
   endtask

   task automatic test_async_reset();
      logic [7:0] v;
      load_val(8'h10, 1, 0, 0);
      preload(4'd0, 8'h29);
      ld_bus = 3'd0; ld_MAR = 1; tick();
      ld_bus = 3'd5; ld_IR = 1; tick();
      n_checks++; if (opcode !== 3'b001) begin n_fail++; $display("FAIL pre_reset_opcode got %b want 001", opcode); end
      for (int i = 0; i < 16 && pc !== 4'd5; i++) begin inc_PC = 1; tick(); end
      n_checks++; if (pc !== 4'd5) begin n_fail++; $display("FAIL pre_reset_pc got %h want 5", pc); end
      ld_bus = 3'd3; ld_out = 1; tx = 1; tick();
      n_checks++; if (out_data !== 8'h10) begin n_fail++; $display("FAIL pre_reset_out got %h want 10", out_data); end
      // Mid-cycle reset: no clock edge between assertion and the checks.
      rst_n = 0;
      #1;
      n_checks++; if (pc !== 4'd0) begin n_fail++; $display("FAIL async_pc got %h want 0", pc); end
      n_checks++; if (opcode !== 3'd0) begin n_fail++; $display("FAIL async_opcode got %h want 0", opcode); end
      n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL async_out got %h want 00", out_data); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid got %b want 0", out_valid); end
      #1;
      rst_n = 1;
      ld_bus = 3'd1; ld_MAR = 1; tick();
      ld_bus = 3'd5; ld_IR = 1; inc_PC = 1; tick();
      n_checks++; if (opcode !== 3'b001) begin n_fail++; $display("FAIL post_reset_opcode got %b want 001", opcode); end
      n_checks++; if (pc !== 4'd1) begin n_fail++; $display("FAIL post_reset_pc got %h want 1", pc); end
      read_src(3'd2, v);
      n_checks++; if (v !== 8'h09) begin n_fail++; $display("FAIL post_reset_operand got %h want 09", v); end
      read_src(3'd3, v);
      n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL post_reset_acc got %h want 00", v); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      idle();
      rst_n = 0;
      #12;
      rst_n = 1;
      test_reset();
      test_fetch();
      test_alu();
      test_pc();
      test_ram_collision();
      test_out();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sap_datapath.md
# sap_datapath

Register-level datapath for the SAP computer: program counter, MAR, 16x8 RAM, instruction register, accumulator, B register, adder/subtractor and output register, all tied to a single 8-bit internal bus. It is the responder to `instruction_decoder`: it executes the control word the decoder drives each cycle and returns the current opcode from the IR. It also has a host-side port to preload the RAM with a program.

## Interface
- `WIDTH`, 8: data/bus width. Fixed at 8 for this revision.
- `AW`, 4: RAM address and PC width, giving 16 words.
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `inc_PC`  in  1  PC <= PC+1
- `ld_MAR`  in  1  MAR <= bus[3:0]
- `ld_IR`  in  1  IR <= bus
- `ld_ACC`  in  1  ACC <= bus
- `ld_Breg`  in  1  B <= bus
- `ld_out`  in  1  OUT <= bus
- `ld_bus`  in  3  bus source select (see Operation)
- `mem_wr`  in  1  RAM[MAR] <= bus
- `cin`  in  1  ALU mode: 0 = ACC+B, 1 = ACC-B (ACC + ~B + 1)
- `sum`  in  1  capture ALU flags this edge
- `tx`  in  1  qualifies `ld_out` to raise `out_valid`
- `prog_we`  in  1  host RAM write strobe
- `prog_addr`  in  4  host RAM write address
- `prog_data`  in  8  host RAM write data
- `opcode`  out  3  IR[7:5], fed back to decoder
- `out_data`  out  8  OUT register
- `out_valid`  out  1  one-cycle pulse after an `ld_out & tx` edge
- `pc`  out  4  current PC
- `carry`, `zero`  out  1 each  ALU flags

## Operation
- Bus (combinational) by `ld_bus`: 0 = 8'h00, 1 = {4'h0,PC}, 2 = {4'h0,IR[3:0]}, 3 = ACC, 4 = ALU result, 5 = RAM[MAR], 6 = B, 7 = 8'h00.
- IR format: [7:5] opcode, [4] reserved (stored, ignored), [3:0] operand address.
- ALU: 9-bit internal result, computed combinationally from current ACC/B. Result = low 8 bits, wrapping modulo 256.
- Flags are registered only on edges where `sum`=1. `carry` = bit 8 of the 9-bit result; for subtract, 1 = no borrow. `zero` = (result == 0).
- PC increments 4-bit and wraps 15 -> 0.
- All `ld_*`, `inc_PC`, `mem_wr` are independent. Multiple loads in one cycle all capture the same bus value.
- Read-before-write everywhere: a register loaded from itself via the bus, or a PC that is both bus source and incremented, uses the pre-edge value.
- RAM: asynchronous read at MAR, synchronous write. `prog_we` has priority over `mem_wr` when both are asserted; the `mem_wr` is dropped that cycle, even if addresses differ.
- `out_valid` <= `ld_out & tx`, registered. `out_data` updates on any `ld_out`, regardless of `tx`.

## Timing
- Reset (async assert, released synchronously by the environment) clears PC, MAR, IR, ACC, B, OUT, `carry`, `zero` and `out_valid` to 0, so `opcode` = 0. RAM contents are not reset; host preload survives reset.
- Latency:
  - Control word sampled at edge N; register contents visible on outputs after edge N.
  - `opcode` reflects a new IR one cycle after the `ld_IR` edge.
  - RAM write at edge N is readable through the bus in cycle N+1.
  - `out_valid` is high for exactly the cycle after the `ld_out & tx` edge. Back-to-back strobes hold it high continuously.
- Reset asserted mid-instruction clears state immediately, without waiting for a clock edge. An in-flight `mem_wr` or `prog_we` on the same edge as reset assertion is not performed.

## Test plan
- Preload and fetch: preload RAM[0]=8'h29, RAM[9]=8'h05.
  - Cycle 1: `ld_bus`=1, `ld_MAR`.
  - Cycle 2: `ld_bus`=5, `ld_IR`, `inc_PC`.
  - Expect `opcode`=3'b001, `pc`=1, IR operand 9.
- Add and subtract:
  - ACC=8'hF0, B=8'h20, `cin`=0, `sum`=1, `ld_bus`=4, `ld_ACC` -> ACC=8'h10, `carry`=1, `zero`=0.
  - Then with B=8'h10, `cin`=1 -> ACC=8'h00, `carry`=1, `zero`=1.
  - ACC=8'h05, B=8'h06, `cin`=1 -> 8'hFF, `carry`=0.
- PC wrap and read-before-write: 16 `inc_PC` cycles from reset -> `pc`=0. With `inc_PC`, `ld_bus`=1 and `ld_ACC` at PC=7 -> ACC=8'h07, `pc`=8.
- RAM write collision: MAR=3, `mem_wr` with bus=8'hAA, and simultaneously `prog_we` addr 5 data 8'h55 -> RAM[5]=8'h55, RAM[3] unchanged. Next cycle `mem_wr` alone -> RAM[3]=8'hAA.
- Output strobe: `ld_out` with bus=8'h3C and `tx`=0 -> `out_data`=8'h3C, `out_valid` stays 0. Repeat with `tx`=1 -> `out_valid` high exactly one cycle.
- Async reset mid-run: drop `rst_n` between edges with ACC=8'h10, PC=5 -> all registers 0 immediately, preloaded RAM intact, first post-reset fetch reads RAM[0].
